// File: rtl/alu4b_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu4b_arbiter
//  Purpose  : Shares a single alu4b instance between two requesters. A
//             requester posts an op code and two 4-bit operands with a
//             req/ack handshake. The block grants one requester, drives the
//             ALU inputs from registers, and captures the seven-segment
//             pattern and the carry for that op into response registers.
//  Build    : define ALU_ARB_RR_EN for round-robin arbitration. When it is
//             left undefined, arbitration is fixed priority and requester 0
//             wins a tie.
//  Ports    :
//    clk            in   rising-edge clock
//    rst            in   synchronous reset, active-high
//    req0/req1      in   request from requester 0 / 1
//    op0/op1  [1:0] in   00 add, 01 sub, 10 AND, 11 OR
//    a0,b0,a1,b1    in   4-bit operands per requester
//    alu_a,alu_b    out  registered ALU operands
//    alu_s0,alu_s1  out  registered ALU select lines (s0 = op[0], s1 = op[1])
//    alu_seg  [6:0] in   ALU seg_out
//    alu_cout_som   in   ALU carry for add
//    alu_cout_sub   in   ALU carry for sub
//    ack0/ack1      out  one-cycle completion pulse per requester
//    rsp_seg  [6:0] out  captured segment pattern
//    rsp_cout       out  captured carry (0 for logic ops)
//    rsp_id         out  requester that owns the current response
//    busy           out  high while an operation is in flight
//  Revision : 1.0  initial release
// ============================================================================
module alu4b_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_s0,
    output logic       alu_s1,
    input  logic [6:0] alu_seg,
    input  logic       alu_cout_som,
    input  logic       alu_cout_sub,
    output logic       ack0,
    output logic       ack1,
    output logic [6:0] rsp_seg,
    output logic       rsp_cout,
    output logic       rsp_id,
    output logic       busy
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;

    logic [1:0] r_state;
    logic [1:0] w_state_next;

    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic       r_alu_s0;
    logic       r_alu_s1;
    logic       r_ack0;
    logic       r_ack1;
    logic [6:0] r_rsp_seg;
    logic       r_rsp_cout;
    logic       r_rsp_id;

    logic       w_req_any;
    logic       w_win_id;
    logic       w_grant;
    logic       w_capture;
    logic       w_cout_sel;
    logic [1:0] w_win_op;
    logic [3:0] w_win_a;
    logic [3:0] w_win_b;

    assign w_req_any = req0 | req1;

    // ------------------------------------------------------------------
    // Arbitration. A lone requester always wins; the preference only
    // matters when both requests are high on the same edge.
    // ------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
    logic r_rr_ptr;

    always_comb begin
        w_win_id = 1'b0;
        if (req0 && req1) begin
            w_win_id = r_rr_ptr;
        end else begin
            w_win_id = req1;
        end
    end

    // After every grant the preference moves to the requester that lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_grant) begin
            r_rr_ptr <= ~w_win_id;
        end
    end
`else
    always_comb begin
        w_win_id = 1'b0;
        if (!req0 && req1) begin
            w_win_id = 1'b1;
        end
    end
`endif

    // Winner's request fields, muxed once so the grant path stays simple.
    always_comb begin
        w_win_op = op0;
        w_win_a  = a0;
        w_win_b  = b0;
        if (w_win_id) begin
            w_win_op = op1;
            w_win_a  = a1;
            w_win_b  = b1;
        end
    end

    // Carry selection uses the registered select lines, i.e. the op the
    // ALU is actually evaluating during EXEC.
    always_comb begin
        w_cout_sel = 1'b0;
        case ({r_alu_s1, r_alu_s0})
            c_OP_ADD: w_cout_sel = alu_cout_som;
            c_OP_SUB: w_cout_sel = alu_cout_sub;
            default:  w_cout_sel = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-state strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_req_any) begin
                    w_grant      = 1'b1;
                    w_state_next = c_EXEC;
                end
            end
            c_EXEC: begin
                w_capture    = 1'b1;
                w_state_next = c_DONE;
            end
            c_DONE: begin
                // Requests are deliberately ignored here; a req still high
                // on the next IDLE edge is treated as a fresh request.
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a    <= 4'h0;
            r_alu_b    <= 4'h0;
            r_alu_s0   <= 1'b0;
            r_alu_s1   <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rsp_seg  <= 7'h00;
            r_rsp_cout <= 1'b0;
            r_rsp_id   <= 1'b0;
        end else begin
            // ack is a single-cycle pulse: cleared unless this is the
            // capture edge.
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;

            // Operands are sampled only at grant and then held, so the ALU
            // sees stable inputs for all of EXEC and keeps them in IDLE.
            if (w_grant) begin
                r_alu_a  <= w_win_a;
                r_alu_b  <= w_win_b;
                r_alu_s0 <= w_win_op[0];
                r_alu_s1 <= w_win_op[1];
                r_rsp_id <= w_win_id;
            end

            if (w_capture) begin
                r_rsp_seg  <= alu_seg;
                r_rsp_cout <= w_cout_sel;
                r_ack0     <= ~r_rsp_id;
                r_ack1     <= r_rsp_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_s0   = r_alu_s0;
    assign alu_s1   = r_alu_s1;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign rsp_seg  = r_rsp_seg;
    assign rsp_cout = r_rsp_cout;
    assign rsp_id   = r_rsp_id;
    assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu4b_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu4b_arbiter
//  Purpose  : Self-checking bench for alu4b_arbiter. A behavioural alu4b
//             stands in for the real ALU. A transaction-level reference
//             model predicts every output on every cycle. The bench applies
//             the directed scenarios first and then randomized traffic with
//             occasional resets. Define ALU_ARB_RR_EN to check the
//             round-robin build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu4b_arbiter;

    logic       clk = 1'b0;
    logic       rst, req0, req1;
    logic [1:0] op0, op1;
    logic [3:0] a0, b0, a1, b1;
    logic [3:0] alu_a, alu_b;
    logic       alu_s0, alu_s1;
    logic [6:0] alu_seg;
    logic       alu_cout_som, alu_cout_sub;
    logic       ack0, ack1;
    logic [6:0] rsp_seg;
    logic       rsp_cout, rsp_id, busy;

    always #5 clk = ~clk;

    alu4b_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .op0          (op0),
        .op1          (op1),
        .a0           (a0),
        .b0           (b0),
        .a1           (a1),
        .b1           (b1),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_s0       (alu_s0),
        .alu_s1       (alu_s1),
        .alu_seg      (alu_seg),
        .alu_cout_som (alu_cout_som),
        .alu_cout_sub (alu_cout_sub),
        .ack0         (ack0),
        .ack1         (ack1),
        .rsp_seg      (rsp_seg),
        .rsp_cout     (rsp_cout),
        .rsp_id       (rsp_id),
        .busy         (busy)
    );

    // ------------------------------------------------------------------
    // Behavioural alu4b: 4-bit result shown on an active-high gfedcba
    // seven-segment pattern; carry for add, no-borrow flag for sub.
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] tab [16];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tab[v];
    endfunction

    function automatic logic [3:0] alu_result(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b) + 16;
            2'd2:    r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return 4'(r % 16);
    endfunction

    assign alu_seg      = seg7(alu_result({alu_s1, alu_s0}, alu_a, alu_b));
    assign alu_cout_som = (int'(alu_a) + int'(alu_b)) > 15;
    assign alu_cout_sub = (alu_a >= alu_b);

    // ------------------------------------------------------------------
    // Reference model: a transaction granted at edge g is busy for edges
    // g and g+1, acks at edge g+1, and frees the ALU at edge g+2.
    // ------------------------------------------------------------------
    int         n_vec = 0;
    int         n_bad = 0;
    int         m_busy_left;
    logic       m_ptr;
    logic [1:0] p_op;
    logic [3:0] p_a, p_b;
    logic [3:0] e_alu_a, e_alu_b;
    logic [1:0] e_op;
    logic       e_ack0, e_ack1, e_cout, e_id;
    logic [6:0] e_seg;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic win;
        if (rst) begin
            m_busy_left = 0;
            m_ptr       = 1'b0;
            e_alu_a     = 4'h0;
            e_alu_b     = 4'h0;
            e_op        = 2'd0;
            e_ack0      = 1'b0;
            e_ack1      = 1'b0;
            e_seg       = 7'h00;
            e_cout      = 1'b0;
            e_id        = 1'b0;
        end else begin
            e_ack0 = 1'b0;
            e_ack1 = 1'b0;
            if (m_busy_left == 2) begin
                e_seg  = seg7(alu_result(p_op, p_a, p_b));
                e_cout = (p_op == 2'd0) ? ((int'(p_a) + int'(p_b)) > 15) :
                         (p_op == 2'd1) ? (p_a >= p_b) : 1'b0;
                if (e_id) e_ack1 = 1'b1;
                else      e_ack0 = 1'b1;
                m_busy_left = 1;
            end else if (m_busy_left == 1) begin
                m_busy_left = 0;
            end else if (req0 || req1) begin
`ifdef ALU_ARB_RR_EN
                win   = (req0 && req1) ? m_ptr : req1;
                m_ptr = ~win;
`else
                win = !req0;
`endif
                p_op        = win ? op1 : op0;
                p_a         = win ? a1 : a0;
                p_b         = win ? b1 : b0;
                e_alu_a     = p_a;
                e_alu_b     = p_b;
                e_op        = p_op;
                e_id        = win;
                m_busy_left = 2;
            end
        end
    endtask

    task automatic check_all();
        check("ack0",     8'(ack0),     8'(e_ack0));
        check("ack1",     8'(ack1),     8'(e_ack1));
        check("busy",     8'(busy),     8'(m_busy_left != 0));
        check("rsp_seg",  8'(rsp_seg),  8'(e_seg));
        check("rsp_cout", 8'(rsp_cout), 8'(e_cout));
        check("rsp_id",   8'(rsp_id),   8'(e_id));
        check("alu_a",    8'(alu_a),    8'(e_alu_a));
        check("alu_b",    8'(alu_b),    8'(e_alu_b));
        check("alu_s",    8'({alu_s1, alu_s0}), 8'(e_op));
    endtask

    // One clock: drive after the falling edge, model the rising edge,
    // check at the next falling edge.
    task automatic step(input logic s_rst, input logic s_r0, input logic s_r1,
                        input logic [1:0] s_o0, input logic [1:0] s_o1,
                        input logic [3:0] s_a0, input logic [3:0] s_b0,
                        input logic [3:0] s_a1, input logic [3:0] s_b1);
        rst  = s_rst;
        req0 = s_r0;
        req1 = s_r1;
        op0  = s_o0;
        op1  = s_o1;
        a0   = s_a0;
        b0   = s_b0;
        a1   = s_a1;
        b1   = s_b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        op0 = 2'd0; op1 = 2'd0; a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        m_busy_left = 0; m_ptr = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        step(1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 4'd15, 4'd15, 4'd15, 4'd15);

        // req0 add 10 + 6: carry out, result 0
        step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd10, 4'd6, 4'd0, 4'd0);
        idle(4);

        // req1 sub 10 - 6: result 4
        step(1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 4'd0, 4'd0, 4'd10, 4'd6);
        idle(4);

        // Both held: AND from 0, OR from 1
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 2'd2, 2'd3, 4'd10, 4'd6, 4'd10, 4'd6);
        idle(3);

        // Operand change during EXEC has no effect
        step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd10, 4'd6, 4'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd3, 4'd6, 4'd0, 4'd0);
        idle(3);

        // Reset during EXEC aborts the operation
        step(1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 4'd9, 4'd2, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(3);

        // req0 held: a new grant at every IDLE edge
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd7, 4'd5, 4'd0, 4'd0);
        idle(3);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 2'($urandom), 2'($urandom),
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
